// File: rtl/skolem_lut_engine_pkg.sv
// skolem_pkg: shared types and sizing helpers for the Skolem LUT engine.
//   st_e       engine state (SWEEP only exists when SKOLEM_SWEEP_EN is defined)
//   tbl_bits   total truth-table bits, N_OUT * 2^N_IN
//   cfg_words  number of config words needed to carry the table
package skolem_pkg;

  localparam logic [1:0] S_EMPTY = 2'd0;
  localparam logic [1:0] S_LOAD  = 2'd1;
  localparam logic [1:0] S_READY = 2'd2;
`ifdef SKOLEM_SWEEP_EN
  localparam logic [1:0] S_SWEEP = 2'd3;
`endif

  typedef enum logic [1:0] {
    ST_EMPTY = S_EMPTY,
    ST_LOAD  = S_LOAD,
`ifdef SKOLEM_SWEEP_EN
    ST_READY = S_READY,
    ST_SWEEP = S_SWEEP
`else
    ST_READY = S_READY
`endif
  } st_e;

  function automatic int tbl_bits(input int n_in, input int n_out);
    return n_out * (1 << n_in);
  endfunction

  function automatic int cfg_words(input int n_in, input int n_out, input int cfg_w);
    return (tbl_bits(n_in, n_out) + cfg_w - 1) / cfg_w;
  endfunction

endpackage

// File: rtl/skolem_lut_engine_if.sv
// skolem_lut_engine_if: config, evaluation-input and result channels of the engine.
//   cfg_valid/cfg_ready/cfg_data/cfg_last  word-serial table load
//   cfg_err                                one-cycle pulse on a malformed load
//   tbl_valid                              a complete table is loaded
//   in_valid/in_ready/in_x                 assignment to evaluate
//   out_valid/out_ready/out_x/out_y        result (assignment and Skolem outputs)
// master = traffic source/sink outside the engine, slave = the engine.
interface skolem_lut_engine_if #(
  parameter int N_IN  = 6,
  parameter int N_OUT = 1,
  parameter int CFG_W = 32
);
  logic             cfg_valid;
  logic             cfg_ready;
  logic [CFG_W-1:0] cfg_data;
  logic             cfg_last;
  logic             cfg_err;
  logic             tbl_valid;
  logic             in_valid;
  logic             in_ready;
  logic [N_IN-1:0]  in_x;
  logic             out_valid;
  logic             out_ready;
  logic [N_IN-1:0]  out_x;
  logic [N_OUT-1:0] out_y;

  modport master (
    output cfg_valid, cfg_data, cfg_last, in_valid, in_x, out_ready,
    input  cfg_ready, cfg_err, tbl_valid, in_ready, out_valid, out_x, out_y
  );

  modport slave (
    input  cfg_valid, cfg_data, cfg_last, in_valid, in_x, out_ready,
    output cfg_ready, cfg_err, tbl_valid, in_ready, out_valid, out_x, out_y
  );
endinterface

// File: rtl/skolem_tbl.sv
// skolem_tbl: flat bit-addressable truth-table storage.
//   clk    rising-edge clock
//   we     write enable for one config word
//   widx   word index; word i holds table bits i*CFG_W upward
//   wdata  config word
//   rx     assignment to read
//   ry     ry[o] = table bit o*2^N_IN + rx, combinational
// Contents are deliberately not reset; the owner gates use with its own valid flag.
module skolem_tbl
  import skolem_pkg::*;
#(
  parameter int N_IN  = 6,
  parameter int N_OUT = 1,
  parameter int CFG_W = 32,
  localparam int WORDS  = cfg_words(N_IN, N_OUT, CFG_W),
  localparam int WIDX_W = (WORDS > 1) ? $clog2(WORDS) : 1
) (
  input  logic              clk,
  input  logic              we,
  input  logic [WIDX_W-1:0] widx,
  input  logic [CFG_W-1:0]  wdata,
  input  logic [N_IN-1:0]   rx,
  output logic [N_OUT-1:0]  ry
);
  localparam int DEPTH = 1 << N_IN;

  logic [CFG_W-1:0]       mem [WORDS];
  logic [WORDS*CFG_W-1:0] flat;

  always_ff @(posedge clk) begin
    if (we) begin
      for (int w = 0; w < WORDS; w++) begin
        if (widx == WIDX_W'(w)) mem[w] <= wdata;
      end
    end
  end

  for (genvar w = 0; w < WORDS; w++) begin : g_flat
    assign flat[w*CFG_W +: CFG_W] = mem[w];
  end

  // Each output channel owns a contiguous 2^N_IN-bit row; padding above is never read.
  for (genvar o = 0; o < N_OUT; o++) begin : g_rd
    logic [DEPTH-1:0] row;
    assign row   = flat[o*DEPTH +: DEPTH];
    assign ry[o] = row[rx];
  end
endmodule

// File: rtl/skolem_lut_engine.sv
// skolem_lut_engine: run-time loadable truth-table evaluator for Skolem functions.
//   clk          rising-edge clock
//   rst_n        synchronous active-low reset (aborts load/sweep, table RAM kept)
//   bus          skolem_lut_engine_if.slave: config load, input assignment, result
//   sweep_start  request a full 0..2^N_IN-1 dump   (only with SKOLEM_SWEEP_EN)
//   sweep_busy   sweep in progress                 (only with SKOLEM_SWEEP_EN)
// Optional feature macro: SKOLEM_SWEEP_EN (sweep ports, SWEEP state, x counter).
module skolem_lut_engine
  import skolem_pkg::*;
#(
  parameter int N_IN  = 6,
  parameter int N_OUT = 1,
  parameter int CFG_W = 32
) (
  input  logic clk,
  input  logic rst_n,
`ifdef SKOLEM_SWEEP_EN
  input  logic sweep_start,
  output logic sweep_busy,
`endif
  skolem_lut_engine_if.slave bus
);
  localparam int WORDS  = cfg_words(N_IN, N_OUT, CFG_W);
  localparam int WIDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
  // One extra code so the index can sit past WORDS-1 and still flag a late cfg_last.
  localparam int CNT_W  = $clog2(WORDS + 1);

  st_e              state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] bidx;
  logic             cfg_ready, in_ready;
  logic             cfg_fire, in_fire, out_fire;
  logic             last_ok, we;
  logic             cfg_err;
  logic             out_valid;
  logic [N_IN-1:0]  out_x;
  logic [N_OUT-1:0] out_y;
  logic [N_IN-1:0]  rd_x;
  logic [N_OUT-1:0] rd_y;
`ifdef SKOLEM_SWEEP_EN
  logic [N_IN-1:0]  sw_x;
  logic             sweep_go;
`endif

  always_comb begin
    cfg_ready = 1'b0;
    case (state)
      ST_EMPTY, ST_LOAD: cfg_ready = 1'b1;
      ST_READY:          cfg_ready = !out_valid;
      default:           cfg_ready = 1'b0;
    endcase
  end

  assign in_ready = (state == ST_READY) && (!out_valid || bus.out_ready);
  assign cfg_fire = bus.cfg_valid && cfg_ready;
  assign in_fire  = bus.in_valid && in_ready;
  assign out_fire = out_valid && bus.out_ready;

  // The first beat of a load (from EMPTY or READY) is always index 0.
  assign bidx    = (state == ST_LOAD) ? cnt : '0;
  assign last_ok = (bidx == CNT_W'(WORDS - 1));
  assign we      = cfg_fire && (bidx < CNT_W'(WORDS));

`ifdef SKOLEM_SWEEP_EN
  // Config and a same-cycle input beat both take precedence over a sweep request.
  assign sweep_go = (state == ST_READY) && sweep_start && !out_valid && !cfg_fire && !in_fire;
  assign rd_x     = ((state == ST_SWEEP) || sweep_go) ? sw_x : bus.in_x;
`else
  assign rd_x     = bus.in_x;
`endif

  skolem_tbl #(.N_IN(N_IN), .N_OUT(N_OUT), .CFG_W(CFG_W)) u_tbl (
    .clk   (clk),
    .we    (we),
    .widx  (bidx[WIDX_W-1:0]),
    .wdata (bus.cfg_data),
    .rx    (rd_x),
    .ry    (rd_y)
  );

  // ---- stage boundary: table lookup -> registered result ----
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_EMPTY;
      cnt       <= '0;
      cfg_err   <= 1'b0;
      out_valid <= 1'b0;
      out_x     <= '0;
      out_y     <= '0;
`ifdef SKOLEM_SWEEP_EN
      sw_x      <= '0;
`endif
    end else begin
      cfg_err <= 1'b0;

      if (cfg_fire) begin
        if (bus.cfg_last) begin
          cnt <= '0;
          if (last_ok) begin
            state <= ST_READY;
          end else begin
            state   <= ST_EMPTY;
            cfg_err <= 1'b1;
          end
        end else begin
          state <= ST_LOAD;
          cnt   <= (bidx == CNT_W'(WORDS)) ? bidx : bidx + 1'b1;
        end
      end
`ifdef SKOLEM_SWEEP_EN
      else if (sweep_go) begin
        state <= ST_SWEEP;
      end
`endif

      if (in_fire) begin
        out_valid <= 1'b1;
        out_x     <= bus.in_x;
        out_y     <= rd_y;
      end
`ifdef SKOLEM_SWEEP_EN
      else if (sweep_go) begin
        out_valid <= 1'b1;
        out_x     <= sw_x;
        out_y     <= rd_y;
        sw_x      <= sw_x + 1'b1;
      end else if ((state == ST_SWEEP) && out_fire) begin
        if (&out_x) begin
          out_valid <= 1'b0;
          state     <= ST_READY;
          sw_x      <= '0;
        end else begin
          out_x <= sw_x;
          out_y <= rd_y;
          sw_x  <= sw_x + 1'b1;
        end
      end
`endif
      else if (out_fire) begin
        out_valid <= 1'b0;
      end
    end
  end

  assign bus.cfg_ready = cfg_ready;
  assign bus.in_ready  = in_ready;
  assign bus.cfg_err   = cfg_err;
  assign bus.out_valid = out_valid;
  assign bus.out_x     = out_x;
  assign bus.out_y     = out_y;
`ifdef SKOLEM_SWEEP_EN
  assign bus.tbl_valid = (state == ST_READY) || (state == ST_SWEEP);
  assign sweep_busy    = (state == ST_SWEEP);
`else
  assign bus.tbl_valid = (state == ST_READY);
`endif
endmodule

// File: tb/tb_skolem_lut_engine.sv
// Scoreboard bench for skolem_lut_engine (N_IN=6, N_OUT=1, CFG_W=32).
// Expected results come from a bit-array model of the truth table filled
// straight from the load words; a negedge monitor pops and compares.
module tb_skolem_lut_engine;
  localparam int NI = 6;
  localparam int NO = 1;
  localparam int CW = 32;
  localparam int DEPTH = 1 << NI;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  skolem_lut_engine_if #(.N_IN(NI), .N_OUT(NO), .CFG_W(CW)) bus ();
`ifdef SKOLEM_SWEEP_EN
  logic sweep_start = 1'b0;
  logic sweep_busy;
`endif

  skolem_lut_engine #(.N_IN(NI), .N_OUT(NO), .CFG_W(CW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
`ifdef SKOLEM_SWEEP_EN
    .sweep_start (sweep_start),
    .sweep_busy  (sweep_busy),
`endif
    .bus         (bus)
  );

  typedef struct {
    logic [NI-1:0] x;
    logic [NO-1:0] y;
    bit            sw;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   n_out = 0;
  int   ready_mode = 0;   // 0: always ready, 1: random, 2: held low
  bit   ref_tbl [NO*DEPTH];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tmo(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timed out", name);
  endtask

  function automatic logic [NO-1:0] model_y(input logic [NI-1:0] x);
    logic [NO-1:0] y;
    for (int o = 0; o < NO; o++) y[o] = ref_tbl[o*DEPTH + int'(x)];
    return y;
  endfunction

  task automatic model_load(input logic [CW-1:0] w0, input logic [CW-1:0] w1);
    for (int b = 0; b < CW; b++) begin
      if (b < NO*DEPTH) ref_tbl[b] = w0[b];
      if (CW + b < NO*DEPTH) ref_tbl[CW + b] = w1[b];
    end
  endtask

  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0:       bus.out_ready = 1'b1;
      1:       bus.out_ready = 1'($urandom_range(0, 1));
      default: bus.out_ready = 1'b0;
    endcase
  end

  always @(negedge clk) begin : mon
    exp_t e;
    if (rst_n && bus.out_valid && bus.out_ready) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output: got x=%0d with empty scoreboard", bus.out_x);
      end else begin
        e = q.pop_front();
        chk("out_x", 32'(bus.out_x), 32'(e.x));
        chk("out_y", 32'(bus.out_y), 32'(e.y));
`ifdef SKOLEM_SWEEP_EN
        if (e.sw) chk("sweep_busy_during_sweep", 32'(sweep_busy), 1);
`endif
      end
      n_out++;
    end
  end

  task automatic cfg_beat(input logic [CW-1:0] d, input logic l);
    int n = 0;
    bus.cfg_valid = 1'b1;
    bus.cfg_data  = d;
    bus.cfg_last  = l;
    @(negedge clk);
    while (!bus.cfg_ready && n < 200) begin n++; @(negedge clk); end
    if (!bus.cfg_ready) tmo("cfg_ready_wait");
    @(posedge clk);
    #1;
    bus.cfg_valid = 1'b0;
    bus.cfg_last  = 1'b0;
  endtask

  task automatic send_x(input logic [NI-1:0] x, input logic [NO-1:0] y);
    int n = 0;
    bus.in_valid = 1'b1;
    bus.in_x     = x;
    @(negedge clk);
    while (!bus.in_ready && n < 200) begin n++; @(negedge clk); end
    if (!bus.in_ready) tmo("in_ready_wait");
    else q.push_back('{x, y, 1'b0});
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    @(negedge clk);
    while ((q.size() != 0 || bus.out_valid) && n < 2000) begin n++; @(negedge clk); end
    if (q.size() != 0 || bus.out_valid) tmo("drain");
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [CW-1:0] w0, w1;
    logic [NI-1:0] x;
    int base;
    int n;
    bus.cfg_valid = 1'b0;
    bus.cfg_data  = '0;
    bus.cfg_last  = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_x      = '0;

    // Reset values
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_cfg_ready", 32'(bus.cfg_ready), 1);
    chk("rst_cfg_err",   32'(bus.cfg_err),   0);
    chk("rst_tbl_valid", 32'(bus.tbl_valid), 0);
    chk("rst_in_ready",  32'(bus.in_ready),  0);
    chk("rst_out_valid", 32'(bus.out_valid), 0);
    chk("rst_out_x",     32'(bus.out_x),     0);
    chk("rst_out_y",     32'(bus.out_y),     0);
`ifdef SKOLEM_SWEEP_EN
    chk("rst_sweep_busy", 32'(sweep_busy), 0);
`endif

    // Early cfg_last on word 0
    w0 = 32'h1234_5678;
    cfg_beat(w0, 1'b1);
    chk("early_last_err_pulse", 32'(bus.cfg_err), 1);
    chk("early_last_tbl_valid", 32'(bus.tbl_valid), 0);
    @(posedge clk);
    #1;
    chk("early_last_err_cleared", 32'(bus.cfg_err), 0);
    chk("early_last_in_ready", 32'(bus.in_ready), 0);
    chk("early_last_empty_cfg_ready", 32'(bus.cfg_ready), 1);

    // Reference load and the known evaluation points
    w0 = 32'hAAAA_AAAA;
    w1 = 32'hFFFF_0000;
    cfg_beat(w0, 1'b0);
    chk("load_mid_tbl_valid", 32'(bus.tbl_valid), 0);
    cfg_beat(w1, 1'b1);
    model_load(w0, w1);
    chk("load_tbl_valid", 32'(bus.tbl_valid), 1);
    chk("load_in_ready", 32'(bus.in_ready), 1);
    chk("load_no_err", 32'(bus.cfg_err), 0);
    send_x(6'd0,  1'b0);
    send_x(6'd1,  1'b1);
    send_x(6'd32, 1'b0);
    send_x(6'd48, 1'b1);
    wait_drain();
    chk("tbl_valid_after_eval", 32'(bus.tbl_valid), 1);

    // Backpressure with x=1 pending
    ready_mode = 2;
    @(posedge clk);
    #2;
    send_x(6'd1, model_y(6'd1));
    base = n_out;
    repeat (5) begin
      @(negedge clk);
      chk("bp_out_valid", 32'(bus.out_valid), 1);
      chk("bp_out_x", 32'(bus.out_x), 1);
      chk("bp_out_y", 32'(bus.out_y), 32'(model_y(6'd1)));
      chk("bp_in_ready", 32'(bus.in_ready), 0);
    end
    ready_mode = 0;
    repeat (3) @(posedge clk);
    #2;
    chk("bp_one_accept", n_out - base, 1);
    chk("bp_out_valid_clear", 32'(bus.out_valid), 0);

    // Random evaluation under random backpressure
    ready_mode = 1;
    repeat (30) begin
      x = NI'($urandom_range(0, DEPTH - 1));
      send_x(x, model_y(x));
    end
    wait_drain();
    ready_mode = 0;

`ifdef SKOLEM_SWEEP_EN
    // sweep_start is ignored while a result is pending
    ready_mode = 2;
    @(posedge clk);
    #2;
    send_x(6'd3, model_y(6'd3));
    sweep_start = 1'b1;
    @(posedge clk);
    #1 sweep_start = 1'b0;
    chk("sweep_ignored_busy", 32'(sweep_busy), 0);
    ready_mode = 0;
    wait_drain();

    // Full sweep with random out_ready
    ready_mode = 1;
    base = n_out;
    for (int i = 0; i < DEPTH; i++) q.push_back('{NI'(i), model_y(NI'(i)), 1'b1});
    @(posedge clk);
    #1 sweep_start = 1'b1;
    @(posedge clk);
    #1 sweep_start = 1'b0;
    chk("sweep_first_valid", 32'(bus.out_valid), 1);
    chk("sweep_first_x", 32'(bus.out_x), 0);
    chk("sweep_busy_start", 32'(sweep_busy), 1);
    chk("sweep_in_ready", 32'(bus.in_ready), 0);
    chk("sweep_cfg_ready", 32'(bus.cfg_ready), 0);
    wait_drain();
    chk("sweep_busy_end", 32'(sweep_busy), 0);
    chk("sweep_beats", n_out - base, DEPTH);
    chk("sweep_tbl_valid", 32'(bus.tbl_valid), 1);
    ready_mode = 0;
`endif

    // Reload while a result is pending
    ready_mode = 2;
    @(posedge clk);
    #2;
    send_x(6'd5, model_y(6'd5));
    w0 = $urandom;
    w1 = $urandom;
    bus.cfg_valid = 1'b1;
    bus.cfg_data  = w0;
    bus.cfg_last  = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("reload_cfg_ready_hold", 32'(bus.cfg_ready), 0);
    end
    ready_mode = 0;
    cfg_beat(w0, 1'b0);
    cfg_beat(w1, 1'b1);
    model_load(w0, w1);
    chk("reload_tbl_valid", 32'(bus.tbl_valid), 1);
    ready_mode = 1;
    repeat (20) begin
      x = NI'($urandom_range(0, DEPTH - 1));
      send_x(x, model_y(x));
    end
    wait_drain();
    ready_mode = 0;

`ifdef SKOLEM_SWEEP_EN
    // Reset in the middle of a sweep at x=20
    for (int i = 0; i < DEPTH; i++) q.push_back('{NI'(i), model_y(NI'(i)), 1'b1});
    @(posedge clk);
    #1 sweep_start = 1'b1;
    @(posedge clk);
    #1 sweep_start = 1'b0;
    n = 0;
    @(negedge clk);
    while (!(bus.out_valid && bus.out_x == 6'd20) && n < 200) begin n++; @(negedge clk); end
    if (!(bus.out_valid && bus.out_x == 6'd20)) tmo("sweep_reach_x20");
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    q.delete();
    chk("rst_sweep_out_valid", 32'(bus.out_valid), 0);
    chk("rst_sweep_tbl_valid", 32'(bus.tbl_valid), 0);
    chk("rst_sweep_busy", 32'(sweep_busy), 0);
    chk("rst_sweep_in_ready", 32'(bus.in_ready), 0);
    chk("rst_sweep_cfg_ready", 32'(bus.cfg_ready), 1);
`else
    // Reset in the middle of a load
    w0 = $urandom;
    cfg_beat(w0, 1'b0);
    n = 0;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_load_out_valid", 32'(bus.out_valid), 0);
    chk("rst_load_tbl_valid", 32'(bus.tbl_valid), 0);
    chk("rst_load_in_ready", 32'(bus.in_ready), 0);
    chk("rst_load_cfg_ready", 32'(bus.cfg_ready), 1);
`endif
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
